// File: rtl/cfg_reg_arbiter_if.sv
// Requester-side and register-bank-side signals of the configuration write arbiter.
// The arbiter connects through the slave modport. The requesters and the bank, or a
// bench standing in for them, connect through the master modport.
interface cfg_reg_arbiter_if #(
  parameter int NREQ     = 2,
  parameter int NREG     = 4,
  parameter int ADDRW    = 2,
  parameter int SIZEDATA = 5
);
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          req_clr;
  logic [NREQ*ADDRW-1:0]    req_addr;
  logic [NREQ*SIZEDATA-1:0] req_data;
  logic                     clear_all;
  logic [NREQ-1:0]          ack;
  logic                     err;
  logic [NREG-1:0]          reg_enable;
  logic [NREG-1:0]          reg_clear;
  logic [SIZEDATA-1:0]      reg_datain;
  logic                     busy;

  modport master (
    output req, req_clr, req_addr, req_data, clear_all,
    input  ack, err, reg_enable, reg_clear, reg_datain, busy
  );

  modport slave (
    input  req, req_clr, req_addr, req_data, clear_all,
    output ack, err, reg_enable, reg_clear, reg_datain, busy
  );
endinterface

// File: rtl/cfg_reg_arbiter.sv
// Round-robin arbiter that serialises register write/clear requests from NREQ
// sources into single-cycle enable/clear pulses on a bank of NREG registers.
// Each transaction takes three cycles: IDLE (arbitrate), WRITE (pulse), ACK.
// Every output is decoded from the state register and the latched transaction,
// so no combinational path runs from the inputs to the outputs.
module cfg_reg_arbiter #(
  parameter int NREQ     = 2,
  parameter int NREG     = 4,
  parameter int ADDRW    = 2,
  parameter int SIZEDATA = 5
) (
  input  logic             clk,
  input  logic             reset,
  cfg_reg_arbiter_if.slave bus
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDRW:0] NREG_L = (ADDRW+1)'(NREG);

  typedef enum logic [1:0] {IDLE, CLRALL, WRITE, ACK} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PTRW-1:0]     r_ptr;
  logic [PTRW-1:0]     r_win;
  logic [ADDRW-1:0]    r_addr;
  logic                r_clr;
  logic [SIZEDATA-1:0] r_data;

  logic                w_grant;
  logic [PTRW-1:0]     w_sel;
  logic [ADDRW-1:0]    w_sel_addr;
  logic [SIZEDATA-1:0] w_sel_data;
  logic                w_sel_clr;
  logic [NREG-1:0]     w_addr_dec;
  logic                w_addr_ok;
  logic [NREQ-1:0]     w_ack;
  logic                w_err;
  logic [NREG-1:0]     w_enable;
  logic [NREG-1:0]     w_clear;
  logic                w_busy;

  // The first active requester found searching upward from ptr+1 with wrap-around.
  // Scanning from the far end lets the nearest hit overwrite earlier ones, so the
  // loop needs no early exit.
  function automatic logic [PTRW-1:0] f_rr_pick(input logic [NREQ-1:0] req,
                                                input logic [PTRW-1:0] ptr);
    logic [PTRW-1:0] sel;
    sel = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) sel = PTRW'((int'(ptr) + k) % NREQ);
    end
    return sel;
  endfunction

  // Addresses at or beyond NREG have no register behind them.
  function automatic logic f_in_range(input logic [ADDRW-1:0] addr);
    return ({1'b0, addr} < NREG_L);
  endfunction

  assign w_grant    = (r_state == IDLE) && !bus.clear_all && (|bus.req);
  assign w_sel      = f_rr_pick(bus.req, r_ptr);
  assign w_sel_addr = bus.req_addr[w_sel*ADDRW +: ADDRW];
  assign w_sel_data = bus.req_data[w_sel*SIZEDATA +: SIZEDATA];
  assign w_sel_clr  = bus.req_clr[w_sel];
  assign w_addr_ok  = f_in_range(r_addr);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and output decode from the state and the latched transaction.
  always_comb begin
    w_next   = r_state;
    w_ack    = '0;
    w_err    = 1'b0;
    w_enable = '0;
    w_clear  = '0;
    w_busy   = (r_state != IDLE);
    for (int i = 0; i < NREG; i++) w_addr_dec[i] = (r_addr == ADDRW'(i));
    unique case (r_state)
      IDLE: begin
        if (bus.clear_all)   w_next = CLRALL;
        else if (|bus.req)   w_next = WRITE;
      end
      CLRALL: begin
        w_clear = '1;
        w_next  = IDLE;
      end
      WRITE: begin
        if (r_clr) w_clear  = w_addr_dec;
        else       w_enable = w_addr_dec;
        w_next = ACK;
      end
      ACK: begin
        for (int i = 0; i < NREQ; i++) w_ack[i] = (r_win == PTRW'(i));
        w_err  = !w_addr_ok;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the winning request at grant. The bank data bus changes only for an
  // in-range write, so clears and errored requests leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win  <= '0;
      r_addr <= '0;
      r_clr  <= 1'b0;
      r_data <= '0;
    end else if (w_grant) begin
      r_win  <= w_sel;
      r_addr <= w_sel_addr;
      r_clr  <= w_sel_clr;
      if (!w_sel_clr && f_in_range(w_sel_addr)) r_data <= w_sel_data;
    end
  end

  // The round-robin pointer advances to the winner once its ack is issued.
  // Its reset value NREQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_ptr <= PTRW'(NREQ-1);
    else if (r_state == ACK) r_ptr <= r_win;
  end

  assign bus.ack        = w_ack;
  assign bus.err        = w_err;
  assign bus.reg_enable = w_enable;
  assign bus.reg_clear  = w_clear;
  assign bus.reg_datain = r_data;
  assign bus.busy       = w_busy;

endmodule

// File: doc/cfg_reg_arbiter.md
# cfg_reg_arbiter

Round-robin write arbiter for a bank of NREG enable/clear configuration registers shared by NREQ requesters. Each requester posts a write or clear to one register address. The block serialises these requests into single-cycle `enable`/`clear` pulses on the addressed register, plus a common data bus, and acknowledges each requester. It sits between the coprocessor's configuration sources (host interface, local sequencers) and the register bank feeding the datapath.

## Interface
- NREQ, 2: number of requesters (2..8).
- NREG, 4: number of registers in the bank.
- ADDRW, 2: register address width; NREG <= 2^ADDRW.
- SIZEDATA, 5: register data width.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request, level.
- req_clr  in  NREQ  per-requester op select: 1 = clear register, 0 = write data.
- req_addr  in  NREQ*ADDRW  packed addresses; requester i at [i*ADDRW +: ADDRW].
- req_data  in  NREQ*SIZEDATA  packed write data; requester i at [i*SIZEDATA +: SIZEDATA].
- clear_all  in  1  request to clear every register in the bank.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse, coincident with ack, when the granted address is >= NREG.
- reg_enable  out  NREG  one-hot write-enable pulse to the bank.
- reg_clear  out  NREG  clear pulse to the bank.
- reg_datain  out  SIZEDATA  data shared by all bank registers.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, CLRALL, WRITE, ACK. All outputs are registered, or decoded directly from state and latched registers. There is no combinational path from inputs to outputs.
- IDLE, clear_all=1: go to CLRALL. clear_all wins over any req in the same cycle. No ack is issued, and pending reqs wait.
- IDLE, clear_all=0, any req=1: select a winner by round-robin, searching from index (ptr+1) mod NREQ upward with wrap-around.
  - Latch winner index, its addr, data and clr bit; go to WRITE.
- CLRALL: reg_clear = all ones for exactly one cycle; next state IDLE.
- WRITE: lasts one cycle.
  - If latched addr < NREG: if clr=1, assert reg_clear[addr]; else assert reg_enable[addr].
  - If addr >= NREG: no pulse.
  - Next state ACK.
- ACK: lasts one cycle.
  - ack[winner]=1; err=1 if addr >= NREG.
  - ptr <= winner; next state IDLE.
- reg_datain is loaded with the winner's req_data at grant and holds that value until the next grant. Its value is unchanged by clear operations, CLRALL and err transactions.
- Requester protocol:
  - The requester holds req, req_clr, req_addr and req_data stable until it sees ack.
  - A req still high in the cycle after ack is a new request.
  - A req dropped after grant does not abort: the latched transaction completes and is acked.
- reg_enable and reg_clear are never both asserted for the same register. At most one bit of reg_enable is set at any time.
- Reset (reset=0, any time): state=IDLE, ptr=NREQ-1 so requester 0 wins first, latched addr/data/clr/winner=0. Outputs: ack=0, err=0, reg_enable=0, reg_clear=0, reg_datain=0, busy=0.
  - A transaction in flight is dropped with no pulse and no ack.

## Timing
- req sampled high in IDLE at edge k: WRITE pulse during cycle k+1, ack during cycle k+2, next arbitration at edge k+3.
- Throughput: one transaction per 3 cycles. CLRALL costs 2 cycles (CLRALL, then back to IDLE).
- The bank register captures reg_datain at the edge that ends the WRITE cycle, so the value is visible on its output during the ACK cycle.
- busy is high during CLRALL, WRITE and ACK, and low in IDLE.
- Round-robin fairness: with all NREQ requesting continuously, each requester is acked once every 3*NREQ cycles.

## Test plan
- Reset release, req[0]=1, addr=2, data=5'h15, clr=0 -> reg_enable=4'b0100 one cycle later, reg_datain=5'h15, ack=2'b01 the following cycle, err=0.
- req=2'b11 held continuously, distinct addrs -> grant order 0,1,0,1. Ack pulses are 3 cycles apart. No requester is acked twice in a row.
- clear_all=1 together with req[1]=1 in IDLE -> reg_clear=4'b1111 for one cycle with no ack. Then requester 1 is granted, and its ack arrives 4 cycles after clear_all.
- req[1]=1, clr=1, addr=3 -> reg_clear=4'b1000 one cycle, reg_enable=0, reg_datain unchanged, ack=2'b10.
- NREG=3, req[0] with addr=3 -> no reg_enable/reg_clear pulse; ack[0] and err both pulse in the same cycle.
- reset asserted during the WRITE cycle -> all outputs 0 immediately (asynchronous), no ack. After release with req[1]=1 held, requester 1 is granted (ptr back to NREQ-1) and the transaction completes normally.
